// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with thresholds, sticky errors, flush and show-ahead/registered read
module sync_fifo_param #(
   parameter int DW        = 242,
   parameter int DEPTH     = 8,
   parameter int AW        = $clog2(DEPTH),
   parameter int AFULL_TH  = DEPTH - 2,
   parameter int AEMPTY_TH = 1,
   parameter bit FWFT      = 1'b1
) (
   input  logic          iClk,
   input  logic          iRstn,
   input  logic          iFlush,
   input  logic          iWe,
   input  logic [DW-1:0] iWData,
   input  logic          iRe,
   output logic [DW-1:0] oRData,
   output logic          oRValid,
   output logic          oFull,
   output logic          oEmpty,
   output logic          oAFull,
   output logic          oAEmpty,
   output logic [AW:0]   oCount,
   input  logic          iClrErr,
   output logic          oOvf,
   output logic          oUdf
);

   localparam logic [AW:0] DEPTH_C  = (AW + 1)'(DEPTH);
   localparam logic [AW:0] AFULL_C  = (AW + 1)'(AFULL_TH);
   localparam logic [AW:0] AEMPTY_C = (AW + 1)'(AEMPTY_TH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wPtr;
   logic [AW-1:0] rPtr;
   logic [AW:0]   count;
   logic          wAcc;
   logic          rAcc;

   assign oCount  = count;
   assign oFull   = (count == DEPTH_C);
   assign oEmpty  = (count == '0);
   assign oAFull  = (count >= AFULL_C);
   assign oAEmpty = (count <= AEMPTY_C);

   assign wAcc = iWe & ~oFull & ~iFlush;
   assign rAcc = iRe & ~oEmpty & ~iFlush;

   // Pointers wrap naturally because DEPTH is a power of two; count tells full from empty.
   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) begin
         wPtr  <= '0;
         rPtr  <= '0;
         count <= '0;
      end else if (iFlush) begin
         wPtr  <= '0;
         rPtr  <= '0;
         count <= '0;
      end else begin
         if (wAcc) wPtr <= wPtr + 1'b1;
         if (rAcc) rPtr <= rPtr + 1'b1;
         case ({wAcc, rAcc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Set beats clear when both land on the same edge.
   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) begin
         oOvf <= 1'b0;
         oUdf <= 1'b0;
      end else begin
         oOvf <= (iWe & oFull & ~iFlush) | (oOvf & ~iClrErr);
         oUdf <= (iRe & oEmpty & ~iFlush) | (oUdf & ~iClrErr);
      end
   end

   always_ff @(posedge iClk) begin
      if (wAcc) mem[wPtr] <= iWData;
   end

   generate
      if (FWFT) begin : g_showAhead
         assign oRData  = mem[rPtr];
         assign oRValid = ~oEmpty;
      end else begin : g_registered
         always_ff @(posedge iClk or negedge iRstn) begin
            if (!iRstn) begin
               oRData  <= '0;
               oRValid <= 1'b0;
            end else begin
               oRValid <= rAcc;
               if (rAcc) oRData <= mem[rPtr];
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - show-ahead and registered FIFO instances driven in lockstep against a queue model
module tb_sync_fifo_param;

   localparam int DW    = 242;
   localparam int DEPTH = 8;
   localparam int AFTH  = DEPTH - 2;
   localparam int AETH  = 1;

   typedef logic [DW-1:0] word_t;

   logic          iClk    = 1'b0;
   logic          iRstn   = 1'b1;
   logic          iFlush  = 1'b0;
   logic          iWe     = 1'b0;
   logic          iRe     = 1'b0;
   logic          iClrErr = 1'b0;
   logic [DW-1:0] iWData  = '0;

   logic [DW-1:0] rData1, rData0;
   logic          rValid1, rValid0, full1, full0, empty1, empty0;
   logic          aFull1, aFull0, aEmpty1, aEmpty0, ovf1, ovf0, udf1, udf0;
   logic [3:0]    count1, count0;

   int passCnt  = 0;
   int failCnt  = 0;
   int totalCnt = 0;

   word_t q[$];
   bit    mOvf, mUdf, mRv0;
   word_t mRd0;

   sync_fifo_param #(.DW(DW), .DEPTH(DEPTH), .FWFT(1'b1)) dut1 (
      .iClk(iClk), .iRstn(iRstn), .iFlush(iFlush), .iWe(iWe), .iWData(iWData), .iRe(iRe),
      .oRData(rData1), .oRValid(rValid1), .oFull(full1), .oEmpty(empty1), .oAFull(aFull1),
      .oAEmpty(aEmpty1), .oCount(count1), .iClrErr(iClrErr), .oOvf(ovf1), .oUdf(udf1)
   );

   sync_fifo_param #(.DW(DW), .DEPTH(DEPTH), .FWFT(1'b0)) dut0 (
      .iClk(iClk), .iRstn(iRstn), .iFlush(iFlush), .iWe(iWe), .iWData(iWData), .iRe(iRe),
      .oRData(rData0), .oRValid(rValid0), .oFull(full0), .oEmpty(empty0), .oAFull(aFull0),
      .oAEmpty(aEmpty0), .oCount(count0), .iClrErr(iClrErr), .oOvf(ovf0), .oUdf(udf0)
   );

   always #5 iClk = ~iClk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   function automatic word_t rndWord();
      word_t v = '0;
      for (int k = 0; k < 8; k++) v = {v[209:0], 32'($urandom())};
      return v;
   endfunction

   task automatic chk(input string tag, input word_t obs, input word_t exp);
      totalCnt++;
      assert (obs === exp) passCnt++;
      else begin
         failCnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkAll();
      int n = q.size();
      chk("count1",  word_t'(count1),  word_t'(n));
      chk("count0",  word_t'(count0),  word_t'(n));
      chk("full1",   word_t'(full1),   word_t'(n == DEPTH));
      chk("full0",   word_t'(full0),   word_t'(n == DEPTH));
      chk("empty1",  word_t'(empty1),  word_t'(n == 0));
      chk("empty0",  word_t'(empty0),  word_t'(n == 0));
      chk("afull1",  word_t'(aFull1),  word_t'(n >= AFTH));
      chk("afull0",  word_t'(aFull0),  word_t'(n >= AFTH));
      chk("aempty1", word_t'(aEmpty1), word_t'(n <= AETH));
      chk("aempty0", word_t'(aEmpty0), word_t'(n <= AETH));
      chk("ovf1",    word_t'(ovf1),    word_t'(mOvf));
      chk("ovf0",    word_t'(ovf0),    word_t'(mOvf));
      chk("udf1",    word_t'(udf1),    word_t'(mUdf));
      chk("udf0",    word_t'(udf0),    word_t'(mUdf));
      chk("rvalid1", word_t'(rValid1), word_t'(n != 0));
      if (n != 0) chk("rdata1", rData1, q[0]);
      chk("rvalid0", word_t'(rValid0), word_t'(mRv0));
      chk("rdata0",  rData0, mRd0);
   endtask

   task automatic doReset();
      iRstn = 1'b0;
      #1;
      q.delete();
      mOvf = 1'b0;
      mUdf = 1'b0;
      mRv0 = 1'b0;
      mRd0 = '0;
      checkAll();
      iWe = 1'b0; iRe = 1'b0; iFlush = 1'b0; iClrErr = 1'b0;
      @(negedge iClk);
      iRstn = 1'b1;
   endtask

   task automatic cyc(input bit we, input word_t wd, input bit re, input bit fl, input bit clr);
      bit full, empty, wAcc, rAcc;
      iWe = we; iWData = wd; iRe = re; iFlush = fl; iClrErr = clr;
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      wAcc  = we && !full && !fl;
      rAcc  = re && !empty && !fl;
      @(posedge iClk);
      mOvf = (we && full && !fl) || (mOvf && !clr);
      mUdf = (re && empty && !fl) || (mUdf && !clr);
      if (fl) begin
         q.delete();
         mRv0 = 1'b0;
      end else begin
         mRv0 = rAcc;
         if (rAcc) mRd0 = q.pop_front();
         if (wAcc) q.push_back(wd);
      end
      #1;
      checkAll();
   endtask

   initial begin
      #2;
      doReset();

      for (int i = 1; i <= 8; i++) cyc(1, word_t'(i), 0, 0, 0);
      cyc(1, word_t'('hAA), 0, 0, 0);
      for (int i = 0; i < 8; i++) cyc(0, '0, 1, 0, 0);
      cyc(0, '0, 0, 0, 1);

      for (int i = 1; i <= 8; i++) cyc(1, word_t'(i), 0, 0, 0);
      cyc(1, word_t'('hBB), 1, 0, 0);
      for (int i = 0; i < 7; i++) cyc(0, '0, 1, 0, 0);
      cyc(1, word_t'('hCC), 1, 0, 0);
      cyc(0, '0, 0, 0, 1);
      cyc(0, '0, 1, 0, 0);

      for (int i = 0; i < 3; i++) cyc(1, word_t'('h100 + i), 0, 0, 0);
      for (int i = 0; i < 20; i++) cyc(1, word_t'('h200 + i), 1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0, 0);

      cyc(1, word_t'('h55), 0, 0, 0);
      cyc(1, word_t'('h66), 0, 0, 0);
      cyc(0, '0, 1, 0, 0);
      cyc(0, '0, 1, 0, 0);
      cyc(0, '0, 0, 0, 0);

      for (int i = 0; i < 5; i++) cyc(1, rndWord(), 0, 0, 0);
      cyc(1, word_t'('hDD), 0, 1, 0);
      cyc(0, '0, 0, 0, 0);

      for (int i = 0; i < 8; i++) cyc(1, rndWord(), 0, 0, 0);
      cyc(1, word_t'('hEE), 0, 0, 1);
      cyc(0, '0, 0, 0, 1);

      for (int i = 0; i < 400; i++) begin
         int wp = ((i / 50) % 2 == 0) ? 75 : 25;
         cyc($urandom_range(0, 99) < wp, rndWord(), $urandom_range(0, 99) < (100 - wp),
             $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0);
      end

      for (int i = 0; i < 4; i++) cyc(1, rndWord(), 0, 0, 0);
      #2;
      doReset();
      cyc(1, word_t'('h77), 0, 0, 0);
      cyc(0, '0, 1, 0, 0);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO, the successor to the fixed 8x242 packet-engine FIFO. Width and depth are configurable. Adds correct full/empty flags and an occupancy count. Adds programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a selectable show-ahead or registered read mode. Used between PEC pipeline stages and for header/descriptor buffering.

Parameters:
DW, 242, data width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AW, $clog2(DEPTH), pointer width; derived, not overridden
AFULL_TH, DEPTH-2, oAFull asserts when count >= AFULL_TH (1..DEPTH)
AEMPTY_TH, 1, oAEmpty asserts when count <= AEMPTY_TH (0..DEPTH-1)
FWFT, 1, 1 = show-ahead read; 0 = registered read with 1-cycle latency

Ports:
iClk  in  1  clock, rising edge
iRstn  in  1  reset, asynchronous, active-low
iFlush  in  1  synchronous flush; empties the FIFO
iWe  in  1  write request
iWData  in  DW  write data
iRe  in  1  read request
oRData  out  DW  read data
oRValid  out  1  oRData valid; FWFT=1: equals ~oEmpty; FWFT=0: 1-cycle pulse after an accepted read
oFull  out  1  count == DEPTH
oEmpty  out  1  count == 0
oAFull  out  1  count >= AFULL_TH
oAEmpty  out  1  count <= AEMPTY_TH
oCount  out  AW+1  current occupancy, 0..DEPTH
iClrErr  in  1  clears the sticky error flags
oOvf  out  1  sticky: write attempted while full
oUdf  out  1  sticky: read attempted while empty

Behaviour:
- Reset (iRstn=0, async): wPtr=rPtr=0, count=0, oEmpty=1, oFull=0, oAEmpty=1, oAFull=0 (oAFull=1 only if AFULL_TH==0, which is illegal), oRValid=0, oOvf=oUdf=0. FWFT=0: oRData register=0. Memory contents are not reset.
- Write accepted (wAcc) = iWe & ~oFull & ~iFlush. On wAcc: mem[wPtr] <= iWData and wPtr increments, wrapping DEPTH-1 -> 0.
- Read accepted (rAcc) = iRe & ~oEmpty & ~iFlush. On rAcc: rPtr increments with wrap.
- Count: +1 on wAcc only; -1 on rAcc only; unchanged when both or neither. Never exceeds DEPTH and never goes below 0.
- Simultaneous read+write:
  - When full: read accepted, write rejected. oOvf sets because the flag uses the pre-edge oFull.
  - When empty: write accepted, read rejected, oUdf sets. With FWFT=1 the written word appears on oRData the next cycle.
- oFull, oEmpty, oAFull, oAEmpty are registered-equivalent. They derive from count, so they change the cycle after the causing edge.
- FWFT=1: oRData = mem[rPtr] combinationally. The head word is valid whenever oEmpty=0, and the read consumes it at the edge.
- FWFT=0: on rAcc, oRData <= mem[rPtr] and oRValid <= 1; otherwise oRValid <= 0 and oRData holds.
- iFlush (takes precedence over iWe/iRe): wPtr=rPtr=count=0 next edge; oRValid <= 0. Error flags and oRData are unaffected.
- Errors: oOvf sets on iWe & oFull & ~iFlush; oUdf sets on iRe & oEmpty & ~iFlush. Both clear on iClrErr. If set and clear fall on the same edge, set wins. Rejected accesses change no pointer or data.
- Pointer wrap: count disambiguates full from empty when wPtr == rPtr.
- Reset mid-operation: all state returns to reset values immediately. In-flight data is discarded.

Test Plan:
- Reset, then write 8 words 0x1..0x8 (DEPTH=8, FWFT=1) -> oCount steps 1..8; oAFull rises at count 6; oFull=1 after the 8th; oRData=0x1 from the cycle after the first write.
- Full FIFO, iWe=1 with 0xAA -> write dropped, oOvf=1, oCount=8. Read 8 words -> 0x1..0x8 in order, oEmpty=1, oAEmpty=1 at count<=1.
- Full FIFO, iWe=iRe=1 for 1 cycle -> oCount=8→7, oOvf=1, head advances to 0x2. Empty FIFO, iWe=iRe=1 -> oCount=1, oUdf=1.
- Steady streaming of 20 words with iWe=iRe=1 at count=3 -> pointers wrap twice, output order intact, oCount stays 3.
- FWFT=0: write 0x55, 0x66; assert iRe for 2 cycles -> oRValid high on the following 2 cycles with oRData 0x55 then 0x66.
- Count 5 plus iFlush with iWe=1 -> oCount=0, oEmpty=1, no write; oOvf unchanged. iClrErr with a coincident overflow -> oOvf stays 1.
